// File: rtl/meio_subtrator_pkg.sv
// Shared constants, lane result type and the half-subtract helper for meio_subtrator.
package meio_subtrator_pkg;

   localparam int WIDTH_DEFAULT = 1;
   localparam int CNT_W_DEFAULT = 16;

   typedef struct packed {
      logic s;
      logic c;
   } hs_res_t;

   // One-bit half subtraction a - b: difference and borrow-out.
   function automatic hs_res_t hs(input logic a, input logic b);
      hs_res_t res;
      res.s = a ^ b;
      res.c = ~a & b;
      return res;
   endfunction

endpackage

// File: rtl/meio_subtrator_bit.sv
// Combinational one-bit half-subtractor cell (a - b -> s, c).
module meio_subtrator_bit
   import meio_subtrator_pkg::*;
(
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);

   hs_res_t res_s;

   assign res_s = hs(a, b);
   assign s     = res_s.s;
   assign c     = res_s.c;

endmodule

// File: rtl/meio_subtrator.sv
// Registered WIDTH-lane half-subtractor with a valid qualifier.
// Optional saturating borrow-event counter when BORROW_CNT_EN is defined.
module meio_subtrator
   import meio_subtrator_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter int CNT_W = CNT_W_DEFAULT
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             in_valid,
   output logic [WIDTH-1:0] s,
   output logic [WIDTH-1:0] c,
   output logic             out_valid
`ifdef BORROW_CNT_EN
   ,
   output logic [CNT_W-1:0] borrow_cnt
`endif
);

   logic [WIDTH-1:0] s_next_s;
   logic [WIDTH-1:0] c_next_s;
   logic [WIDTH-1:0] s_r;
   logic [WIDTH-1:0] c_r;
   logic             valid_r;

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      meio_subtrator_bit u_bit (
         .a (a[i]),
         .b (b[i]),
         .s (s_next_s[i]),
         .c (c_next_s[i])
      );
   end

   // Result registers load only on accepted cycles so held data ignores idle inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_r     <= {WIDTH{1'b0}};
         c_r     <= {WIDTH{1'b0}};
         valid_r <= 1'b0;
      end else begin
         valid_r <= in_valid;
         if (in_valid) begin
            s_r <= s_next_s;
            c_r <= c_next_s;
         end
      end
   end

   assign s         = s_r;
   assign c         = c_r;
   assign out_valid = valid_r;

`ifdef BORROW_CNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] cnt_r;

   // Saturating count of accepted cycles where any lane borrows.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (in_valid && (|c_next_s) && (cnt_r != CNT_MAX)) begin
         cnt_r <= cnt_r + CNT_ONE;
      end
   end

   assign borrow_cnt = cnt_r;
`endif

endmodule

// File: tb/tb_meio_subtrator.sv
// Self-checking bench for meio_subtrator: WIDTH=1 and WIDTH=4 instances against an arithmetic model.
module tb_meio_subtrator;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [0:0] a1, b1, s1, c1;
   logic [3:0] a4, b4, s4, c4;
   logic       v1, v4;
`ifdef BORROW_CNT_EN
   logic [1:0] cnt1, cnt4;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   meio_subtrator #(.WIDTH(1), .CNT_W(2)) u_dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a1),
      .b         (b1),
      .in_valid  (in_valid),
      .s         (s1),
      .c         (c1),
      .out_valid (v1)
`ifdef BORROW_CNT_EN
      ,
      .borrow_cnt(cnt1)
`endif
   );

   meio_subtrator #(.WIDTH(4), .CNT_W(2)) u_dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a4),
      .b         (b4),
      .in_valid  (in_valid),
      .s         (s4),
      .c         (c4),
      .out_valid (v4)
`ifdef BORROW_CNT_EN
      ,
      .borrow_cnt(cnt4)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: per-lane integer subtraction, borrow when the result is negative.
   logic [0:0] m_s1 = 1'b0, m_c1 = 1'b0;
   logic [3:0] m_s4 = 4'h0, m_c4 = 4'h0;
   logic       m_v = 1'b0;
   int         m_cnt1 = 0, m_cnt4 = 0;

   function automatic void model_sub(input logic [3:0] x, input logic [3:0] y,
                                     output logic [3:0] d, output logic [3:0] bw);
      for (int i = 0; i < 4; i++) begin
         int diff;
         diff  = int'(x[i]) - int'(y[i]);
         d[i]  = (diff != 0);
         bw[i] = (diff < 0);
      end
   endfunction

   always @(posedge clk or negedge rst_n) begin
      logic [3:0] d1, bw1, d4, bw4;
      if (!rst_n) begin
         m_s1 <= 1'b0; m_c1 <= 1'b0; m_s4 <= 4'h0; m_c4 <= 4'h0;
         m_v <= 1'b0; m_cnt1 <= 0; m_cnt4 <= 0;
      end else begin
         m_v <= in_valid;
         if (in_valid) begin
            model_sub({3'b000, a1}, {3'b000, b1}, d1, bw1);
            model_sub(a4, b4, d4, bw4);
            m_s1 <= d1[0:0]; m_c1 <= bw1[0:0];
            m_s4 <= d4;      m_c4 <= bw4;
            if (bw1 != 4'h0 && m_cnt1 < 3) m_cnt1 <= m_cnt1 + 1;
            if (bw4 != 4'h0 && m_cnt4 < 3) m_cnt4 <= m_cnt4 + 1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      check("cmp_s1", 32'(s1), 32'(m_s1));
      check("cmp_c1", 32'(c1), 32'(m_c1));
      check("cmp_v1", 32'(v1), 32'(m_v));
      check("cmp_s4", 32'(s4), 32'(m_s4));
      check("cmp_c4", 32'(c4), 32'(m_c4));
      check("cmp_v4", 32'(v4), 32'(m_v));
`ifdef BORROW_CNT_EN
      check("cmp_cnt1", 32'(cnt1), 32'(m_cnt1));
      check("cmp_cnt4", 32'(cnt4), 32'(m_cnt4));
`endif
   end

   // Drive one cycle of inputs, then sit just after the sampling edge.
   task automatic apply(input logic x1, input logic y1, input logic [3:0] x4,
                        input logic [3:0] y4, input logic v);
      a1 = x1; b1 = y1; a4 = x4; b4 = y4; in_valid = v;
      @(posedge clk);
      #1;
   endtask

   typedef struct { logic a; logic b; logic s; logic c; } vec_t;
   vec_t vecs[4] = '{'{1'b0, 1'b0, 1'b0, 1'b0}, '{1'b1, 1'b0, 1'b1, 1'b0},
                     '{1'b1, 1'b1, 1'b0, 1'b0}, '{1'b0, 1'b1, 1'b1, 1'b1}};
`ifdef BORROW_CNT_EN
   int cnt_exp[5] = '{1, 2, 3, 3, 3};
`endif

   initial begin
      rst_n = 1'b0; in_valid = 1'b0;
      a1 = 1'b0; b1 = 1'b0; a4 = 4'h0; b4 = 4'h0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_s1", 32'(s1), 32'h0);
      check("rst_c1", 32'(c1), 32'h0);
      check("rst_v1", 32'(v1), 32'h0);
      rst_n = 1'b1;

      // Truth table on the 1-bit instance; fixed 4-lane vector alongside.
      for (int i = 0; i < 4; i++) begin
         apply(vecs[i].a, vecs[i].b, 4'b1010, 4'b0110, 1'b1);
         check("tt_s", 32'(s1), 32'(vecs[i].s));
         check("tt_c", 32'(c1), 32'(vecs[i].c));
         check("tt_v", 32'(v1), 32'h1);
         check("w4_s", 32'(s4), 32'hC);
         check("w4_c", 32'(c4), 32'h4);
      end

      // Idle with X data: outputs hold, valid drops.
      for (int i = 0; i < 3; i++) begin
         apply(1'bx, 1'bx, 4'bxxxx, 4'bxxxx, 1'b0);
         check("idle_v", 32'(v1), 32'h0);
         check("idle_s", 32'(s1), 32'h1);
         check("idle_c", 32'(c1), 32'h1);
         check("idle_s4", 32'(s4), 32'hC);
      end

      // Asynchronous reset in the middle of a cycle.
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_s", 32'(s1), 32'h0);
      check("arst_c", 32'(c1), 32'h0);
      check("arst_v", 32'(v1), 32'h0);
`ifdef BORROW_CNT_EN
      check("arst_cnt", 32'(cnt1), 32'h0);
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // First valid after release, then saturation of the 2-bit counter.
      for (int i = 0; i < 5; i++) begin
         apply(1'b0, 1'b1, 4'b0011, 4'b0101, 1'b1);
         check("post_s", 32'(s1), 32'h1);
         check("post_c", 32'(c1), 32'h1);
         check("post_v", 32'(v1), 32'h1);
         check("post_s4", 32'(s4), 32'h6);
         check("post_c4", 32'(c4), 32'h4);
`ifdef BORROW_CNT_EN
         check("sat_cnt", 32'(cnt1), 32'(cnt_exp[i]));
`endif
      end

      apply(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
